store_buffer: RTL

- Sits directly downstream of the store byte-enable/data alignment stage and directly upstream of the data-memory write port.
- Accepts aligned stores: byte address, 4-bit byte write enable, pre-shifted 32-bit write data.
- Queues stores in a small FIFO and drains them into the data memory whenever the memory port is granted.
- Snoops load addresses and flags a hazard when a pending store targets the same word, so the pipeline can stall the load.

---
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer.sv | 88 ++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: store intake, memory write port, load snoop and status.
// Handshake: a store transfers on a cycle where st_valid && st_ready at the rising edge.
interface store_buffer_if #(
    parameter int ADDR_W = 14
);
    logic              st_valid;
    logic [31:0]       st_addr;
    logic [3:0]        st_wea;
    logic [31:0]       st_data;
    logic              st_ready;
    logic              mem_grant;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wea;
    logic [31:0]       mem_din;
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic              ld_hazard;
    logic              empty;

    modport master (
        output st_valid, st_addr, st_wea, st_data, mem_grant, ld_valid, ld_addr,
        input  st_ready, mem_we, mem_addr, mem_wea, mem_din, ld_hazard, empty
    );

    modport slave (
        input  st_valid, st_addr, st_wea, st_data, mem_grant, ld_valid, ld_addr,
        output st_ready, mem_we, mem_addr, mem_wea, mem_din, ld_hazard, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Circular FIFO of aligned stores draining into the data-memory write port,
// with word-granular load-address snooping for hazard detection.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14
) (
    input  logic         clk,
    input  logic         rst,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [3:0]        wea_q  [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW:0]       count;

    logic              push;
    logic              pop;
    logic              hit;
    logic [PW-1:0]     offset;
    logic [ADDR_W-1:0] st_word;
    logic [ADDR_W-1:0] ld_word;
    logic              unused_addr_bits;

    assign st_word = bus.st_addr[ADDR_W+1:2];
    assign ld_word = bus.ld_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.st_addr[31:ADDR_W+2], bus.st_addr[1:0],
                                bus.ld_addr[31:ADDR_W+2], bus.ld_addr[1:0]};

    // Ready ignores a same-cycle pop, so a full buffer never passes a store through.
    assign bus.st_ready = (count != (PW+1)'(DEPTH));
    assign bus.empty    = (count == '0);
    assign push         = bus.st_valid && bus.st_ready && (bus.st_wea != 4'b0000);
    assign pop          = !bus.empty && bus.mem_grant;

    assign bus.mem_we   = pop;
    assign bus.mem_addr = addr_q[head];
    assign bus.mem_din  = data_q[head];
    assign bus.mem_wea  = pop ? wea_q[head] : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                wea_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail] <= st_word;
                wea_q[tail]  <= bus.st_wea;
                data_q[tail] <= bus.st_data;
                tail         <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head;
            if (({1'b0, offset} < count) && (addr_q[i] == ld_word)) begin
                hit = 1'b1;
            end
        end
        if (push && (st_word == ld_word)) begin
            hit = 1'b1;
        end
    end

    assign bus.ld_hazard = bus.ld_valid && hit;
endmodule
